csr_port_arbiter: RTL and testbench
===================================

# csr_port_arbiter

Shares the CSR file's single address/write/read port between two requesters: the trap sequencer (mepc/mcause writes, mtvec/mepc reads) and the Zicsr instruction unit (CSRRW/S/C read-modify-write). Ownership is registered, so each requester holds the port across multi-cycle sequences. The instruction unit is stalled while it waits. A hold limit guarantees trap entry is never blocked indefinitely by a long instruction access.

## Interface
- MAX_HOLD, 15: maximum consecutive cycles the instruction unit may own the port while a trap request is pending; legal range 1..255.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- trap_req  in  1  trap sequencer requests the port; level, held for the whole sequence.
- trap_address  in  12  CSR address from trap sequencer.
- trap_write_data  in  32  write data from trap sequencer.
- trap_write_enable  in  1  trap sequencer write strobe.
- ins_req  in  1  instruction unit requests the port; level.
- ins_address  in  12  CSR address from instruction unit.
- ins_write_data  in  32  write data from instruction unit.
- ins_write_enable  in  1  instruction unit write strobe.
- csr_read_data  in  32  read data from the CSR file (combinational on csr_address).
- csr_address  out  12  address to the CSR file.
- csr_write_data  out  32  write data to the CSR file.
- csr_write_enable  out  1  write strobe to the CSR file.
- trap_grant  out  1  trap sequencer owns the port (registered).
- ins_grant  out  1  instruction unit owns the port (registered).
- trap_read_data  out  32  csr_read_data when trap_grant, else 0.
- ins_read_data  out  32  csr_read_data when ins_grant, else 0.
- ins_stall  out  1  ins_req & ~ins_grant.
- hold_timeout  out  1  one-cycle registered pulse on forced revocation.

## Operation
- States: IDLE, TRAP_OWN, INS_OWN. trap_grant = (state==TRAP_OWN) and ins_grant = (state==INS_OWN), both decoded from state.
- Port mux is combinational from state:
  - TRAP_OWN drives the trap_* fields.
  - INS_OWN drives the ins_* fields, with csr_write_enable = ins_write_enable.
  - IDLE drives address 0, data 0, csr_write_enable 0.
- A write enable from a non-owner never reaches the CSR file.
- prev_owner register: 1 bit, updated on every exit from TRAP_OWN or INS_OWN.
- Decision rule, applied whenever a new owner is chosen:
  - Only trap_req high -> TRAP_OWN.
  - Only ins_req high -> INS_OWN.
  - Both high -> TRAP_OWN, unless prev_owner==TRAP, in which case -> INS_OWN.
  - Neither high -> IDLE.
- IDLE: apply the decision rule each cycle.
- TRAP_OWN:
  - Stays while trap_req is high.
  - On trap_req low, re-decides in the same edge. Direct handoff to INS_OWN with no IDLE bubble.
  - Never revoked.
- INS_OWN:
  - Stays while ins_req is high.
  - On ins_req low, re-decides in the same edge.
- hold_cnt (8 bits):
  - Cleared on entry to any state and whenever trap_req is low.
  - Increments each INS_OWN cycle with trap_req high; saturates at 255.
- Forced revocation: if state==INS_OWN, trap_req high and hold_cnt==MAX_HOLD-1 at an edge:
  - Next state is TRAP_OWN and hold_timeout=1 for one cycle.
  - The instruction unit sees ins_grant fall and ins_stall rise, and must restart its access.
- Reset values: state IDLE, prev_owner INS, hold_cnt 0, hold_timeout 0.
  - All grants and read-data outputs are 0, so the port outputs are 0.
  - Reset mid-sequence abandons ownership immediately with no write issued after rst rises.

## Timing
- Grant latency: request rising at edge N-1 -> grant high after edge N, i.e. 1 cycle. The CSR port is driven by the owner from that cycle.
- Handoff: owner drops its request before edge N -> the new owner is granted after edge N. There are zero idle cycles between owners.
- Release with no other requester: grant low after the next edge, then port outputs 0.
- Read data is combinational through the arbiter, adding zero cycles of latency beyond the CSR file.
- Revocation: the trap is granted exactly MAX_HOLD cycles after the first INS_OWN cycle in which trap_req is high.
- Simultaneous trap_req rise and ins_req fall in INS_OWN: handoff to TRAP_OWN, hold_timeout stays 0.

## Test plan
- Reset, then trap_req=1 with address 0x341, wdata 0x0000_0100, we=1 -> trap_grant=1 one cycle later; csr_address=0x341, csr_write_data=0x100, csr_write_enable=1; ins_stall=0 while ins_req=0.
- trap_req and ins_req both rise from IDLE after reset -> TRAP_OWN first. Trap drops after 3 cycles -> ins_grant on the next cycle with no idle gap. Repeat the tie -> INS_OWN wins (prev_owner=TRAP).
- INS_OWN with ins_write_enable=1 at 0x300, while trap_req=1 with trap_write_enable=1 at 0x342 -> only the ins write reaches the CSR file; trap_read_data=0.
- MAX_HOLD=4: ins holds the port indefinitely, trap_req rises at cycle T -> TRAP_OWN at T+4, hold_timeout=1 for exactly one cycle, ins_stall=1 afterwards.
- TRAP_OWN with trap_req held 300 cycles while ins_req=1 -> no revocation, hold_timeout stays 0.
- rst asserted mid-INS_OWN while ins_write_enable=1 -> all outputs 0 asynchronously. After rst falls with both requests high -> TRAP_OWN first.

Source files
------------

// File: rtl/csr_port_arbiter.sv
// csr_port_arbiter
// Shares the single CSR file port between the trap sequencer and the Zicsr
// instruction unit. Ownership is registered so a requester keeps the port for
// its whole multi-cycle sequence. The instruction unit can be forced off the
// port after MAX_HOLD cycles of a pending trap, so trap entry always proceeds.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | no owner, port driven to zero
// TRAP_OWN | trap sequencer owns the port, never revoked
// INS_OWN  | instruction unit owns the port, revocable by a waiting trap

module csr_port_arbiter #(
  parameter int MAX_HOLD = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trap_req,
  input  logic [11:0] trap_address,
  input  logic [31:0] trap_write_data,
  input  logic        trap_write_enable,
  input  logic        ins_req,
  input  logic [11:0] ins_address,
  input  logic [31:0] ins_write_data,
  input  logic        ins_write_enable,
  input  logic [31:0] csr_read_data,
  output logic [11:0] csr_address,
  output logic [31:0] csr_write_data,
  output logic        csr_write_enable,
  output logic        trap_grant,
  output logic        ins_grant,
  output logic [31:0] trap_read_data,
  output logic [31:0] ins_read_data,
  output logic        ins_stall,
  output logic        hold_timeout
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    TRAP_OWN = 2'd1,
    INS_OWN  = 2'd2
  } state_t;

  localparam logic OWNER_INS  = 1'b0;
  localparam logic OWNER_TRAP = 1'b1;
  // Revocation fires on the edge where the count reaches MAX_HOLD-1, so the
  // trap is granted exactly MAX_HOLD cycles after it started waiting.
  localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD - 1);

  state_t     state;
  state_t     state_next;
  logic       prev_owner;
  logic [7:0] hold_cnt;
  logic       force_revoke;

  // On a tie the requester that did not own the port last goes first.
  function automatic state_t decide(input logic t_req, input logic i_req, input logic prev);
    if (t_req && i_req) return (prev == OWNER_TRAP) ? INS_OWN : TRAP_OWN;
    if (t_req)          return TRAP_OWN;
    if (i_req)          return INS_OWN;
    return IDLE;
  endfunction

  // Next owner selection, including forced revocation of the instruction unit.
  always_comb begin
    state_next   = state;
    force_revoke = 1'b0;
    case (state)
      IDLE:     state_next = decide(trap_req, ins_req, prev_owner);
      TRAP_OWN: if (!trap_req) state_next = decide(1'b0, ins_req, prev_owner);
      INS_OWN: begin
        // A voluntary release takes precedence, so it never counts as a timeout.
        if (!ins_req) begin
          state_next = decide(trap_req, 1'b0, prev_owner);
        end else if (trap_req && hold_cnt == HOLD_LIMIT) begin
          state_next   = TRAP_OWN;
          force_revoke = 1'b1;
        end
      end
      default:  state_next = IDLE;
    endcase
  end

  // Ownership, fairness history, hold counter and timeout pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      prev_owner   <= OWNER_INS;
      hold_cnt     <= 8'd0;
      hold_timeout <= 1'b0;
    end else begin
      state        <= state_next;
      hold_timeout <= force_revoke;
      if (state == TRAP_OWN && state_next != TRAP_OWN)
        prev_owner <= OWNER_TRAP;
      else if (state == INS_OWN && state_next != INS_OWN)
        prev_owner <= OWNER_INS;
      if (state_next != state || !trap_req)
        hold_cnt <= 8'd0;
      else if (state == INS_OWN && hold_cnt != 8'hFF)
        hold_cnt <= hold_cnt + 8'd1;
    end
  end

  assign trap_grant = (state == TRAP_OWN);
  assign ins_grant  = (state == INS_OWN);
  assign ins_stall  = ins_req & ~ins_grant;

  // Port mux: only the current owner's strobe can reach the CSR file.
  always_comb begin
    csr_address      = 12'd0;
    csr_write_data   = 32'd0;
    csr_write_enable = 1'b0;
    case (state)
      TRAP_OWN: begin
        csr_address      = trap_address;
        csr_write_data   = trap_write_data;
        csr_write_enable = trap_write_enable;
      end
      INS_OWN: begin
        csr_address      = ins_address;
        csr_write_data   = ins_write_data;
        csr_write_enable = ins_write_enable;
      end
      default: begin
        csr_address      = 12'd0;
        csr_write_data   = 32'd0;
        csr_write_enable = 1'b0;
      end
    endcase
  end

  assign trap_read_data = trap_grant ? csr_read_data : 32'd0;
  assign ins_read_data  = ins_grant  ? csr_read_data : 32'd0;

endmodule

// File: tb/tb_csr_port_arbiter.sv
// Testbench for csr_port_arbiter with MAX_HOLD=4. Expected port snapshots are
// queued as stimulus is applied and popped when the DUT output is sampled.

module tb_csr_port_arbiter;

  localparam int MAX_HOLD = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        trap_req, trap_write_enable, ins_req, ins_write_enable;
  logic [11:0] trap_address, ins_address;
  logic [31:0] trap_write_data, ins_write_data;
  logic [31:0] csr_read_data;
  logic [11:0] csr_address;
  logic [31:0] csr_write_data;
  logic        csr_write_enable, trap_grant, ins_grant, ins_stall, hold_timeout;
  logic [31:0] trap_read_data, ins_read_data;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic        tg;
    logic        ig;
    logic        we;
    logic        to;
    logic        st;
    logic [11:0] a;
    logic [31:0] wd;
    logic [31:0] tr;
    logic [31:0] ir;
  } snap_t;

  snap_t sb[$];
  snap_t got, exp_s;

  csr_port_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst(rst),
    .trap_req(trap_req), .trap_address(trap_address),
    .trap_write_data(trap_write_data), .trap_write_enable(trap_write_enable),
    .ins_req(ins_req), .ins_address(ins_address),
    .ins_write_data(ins_write_data), .ins_write_enable(ins_write_enable),
    .csr_read_data(csr_read_data),
    .csr_address(csr_address), .csr_write_data(csr_write_data),
    .csr_write_enable(csr_write_enable),
    .trap_grant(trap_grant), .ins_grant(ins_grant),
    .trap_read_data(trap_read_data), .ins_read_data(ins_read_data),
    .ins_stall(ins_stall), .hold_timeout(hold_timeout)
  );

  always #5 clk = ~clk;

  // CSR file model: read data is a recognisable function of the address.
  assign csr_read_data = {20'hABCDE, csr_address};

  // Expected outputs for a given owner (0 idle, 1 trap, 2 ins) from current inputs.
  function automatic snap_t exp_of(input int owner, input logic to);
    snap_t s;
    s = '0;
    if (owner == 1) begin
      s.tg = 1'b1; s.a = trap_address; s.wd = trap_write_data; s.we = trap_write_enable;
      s.tr = {20'hABCDE, trap_address};
    end else if (owner == 2) begin
      s.ig = 1'b1; s.a = ins_address; s.wd = ins_write_data; s.we = ins_write_enable;
      s.ir = {20'hABCDE, ins_address};
    end
    s.st = ins_req && (owner != 2);
    s.to = to;
    return s;
  endfunction

  function automatic snap_t sample();
    snap_t s;
    s.tg = trap_grant; s.ig = ins_grant; s.we = csr_write_enable;
    s.to = hold_timeout; s.st = ins_stall; s.a = csr_address;
    s.wd = csr_write_data; s.tr = trap_read_data; s.ir = ins_read_data;
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    trap_req = 0; trap_write_enable = 0; trap_address = '0; trap_write_data = '0;
    ins_req = 0; ins_write_enable = 0; ins_address = '0; ins_write_data = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    #2;
    sb.push_back(exp_of(0, 0));
    got = sample(); exp_s = sb.pop_front(); n_tests++;
    if (got !== exp_s) begin n_fail++; $display("FAIL reset got=%h exp=%h", got, exp_s); end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_trap_grant();
    trap_req = 1; trap_address = 12'h341; trap_write_data = 32'h0000_0100; trap_write_enable = 1;
    #1;
    sb.push_back(exp_of(0, 0));
    got = sample(); exp_s = sb.pop_front(); n_tests++;
    if (got !== exp_s) begin n_fail++; $display("FAIL pre_grant got=%h exp=%h", got, exp_s); end
    sb.push_back(exp_of(1, 0));
    tick();
    got = sample(); exp_s = sb.pop_front(); n_tests++;
    if (got !== exp_s) begin n_fail++; $display("FAIL trap_grant got=%h exp=%h", got, exp_s); end
    trap_req = 0; trap_write_enable = 0;
    sb.push_back(exp_of(0, 0));
    tick();
    got = sample(); exp_s = sb.pop_front(); n_tests++;
    if (got !== exp_s) begin n_fail++; $display("FAIL trap_release got=%h exp=%h", got, exp_s); end
  endtask

  task automatic test_tie_and_handoff();
    idle_inputs();
    do_reset();
    trap_req = 1; ins_req = 1; trap_address = 12'h305; ins_address = 12'h340;
    for (int i = 0; i < 3; i++) begin
      sb.push_back(exp_of(1, 0));
      tick();
      got = sample(); exp_s = sb.pop_front(); n_tests++;
      if (got !== exp_s) begin n_fail++; $display("FAIL tie_trap_first c%0d got=%h exp=%h", i, got, exp_s); end
    end
    trap_req = 0;
    sb.push_back(exp_of(2, 0));
    tick();
    got = sample(); exp_s = sb.pop_front(); n_tests++;
    if (got !== exp_s) begin n_fail++; $display("FAIL handoff_no_gap got=%h exp=%h", got, exp_s); end
    ins_req = 0;
    sb.push_back(exp_of(0, 0));
    tick();
    got = sample(); exp_s = sb.pop_front(); n_tests++;
    if (got !== exp_s) begin n_fail++; $display("FAIL ins_release got=%h exp=%h", got, exp_s); end
    trap_req = 1;
    sb.push_back(exp_of(1, 0));
    tick();
    got = sample(); exp_s = sb.pop_front(); n_tests++;
    if (got !== exp_s) begin n_fail++; $display("FAIL trap_solo got=%h exp=%h", got, exp_s); end
    trap_req = 0;
    sb.push_back(exp_of(0, 0));
    tick();
    got = sample(); exp_s = sb.pop_front(); n_tests++;
    if (got !== exp_s) begin n_fail++; $display("FAIL trap_solo_release got=%h exp=%h", got, exp_s); end
    trap_req = 1; ins_req = 1;
    sb.push_back(exp_of(2, 0));
    tick();
    got = sample(); exp_s = sb.pop_front(); n_tests++;
    if (got !== exp_s) begin n_fail++; $display("FAIL tie_ins_wins got=%h exp=%h", got, exp_s); end
  endtask

  // Continues from INS_OWN with trap_req pending (hold count 1 after this edge).
  task automatic test_write_isolation();
    ins_address = 12'h300; ins_write_data = 32'hDEAD_BEEF; ins_write_enable = 1;
    trap_address = 12'h342; trap_write_data = 32'h1234_5678; trap_write_enable = 1;
    sb.push_back(exp_of(2, 0));
    tick();
    got = sample(); exp_s = sb.pop_front(); n_tests++;
    if (got !== exp_s) begin n_fail++; $display("FAIL write_isolation got=%h exp=%h", got, exp_s); end
    trap_req = 0;
    sb.push_back(exp_of(2, 0));
    tick();
    got = sample(); exp_s = sb.pop_front(); n_tests++;
    if (got !== exp_s) begin n_fail++; $display("FAIL trap_withdraw got=%h exp=%h", got, exp_s); end
    ins_req = 0; ins_write_enable = 0; trap_write_enable = 0;
    sb.push_back(exp_of(0, 0));
    tick();
    got = sample(); exp_s = sb.pop_front(); n_tests++;
    if (got !== exp_s) begin n_fail++; $display("FAIL isolation_idle got=%h exp=%h", got, exp_s); end
  endtask

  task automatic test_revocation();
    ins_req = 1; ins_address = 12'h7C0; ins_write_enable = 1; ins_write_data = 32'h55AA_0001;
    sb.push_back(exp_of(2, 0));
    tick();
    got = sample(); exp_s = sb.pop_front(); n_tests++;
    if (got !== exp_s) begin n_fail++; $display("FAIL ins_own got=%h exp=%h", got, exp_s); end
    trap_req = 1; trap_address = 12'h341; trap_write_enable = 1; trap_write_data = 32'h8000_0004;
    for (int i = 1; i <= MAX_HOLD + 1; i++) begin
      if (i < MAX_HOLD)       sb.push_back(exp_of(2, 0));
      else if (i == MAX_HOLD) sb.push_back(exp_of(1, 1));
      else                    sb.push_back(exp_of(1, 0));
      tick();
      got = sample(); exp_s = sb.pop_front(); n_tests++;
      if (got !== exp_s) begin n_fail++; $display("FAIL revoke T+%0d got=%h exp=%h", i, got, exp_s); end
    end
  endtask

  task automatic test_long_trap();
    int bad = 0;
    for (int i = 0; i < 300; i++) begin
      sb.push_back(exp_of(1, 0));
      tick();
      got = sample(); exp_s = sb.pop_front(); n_tests++;
      if (got !== exp_s) begin
        n_fail++;
        if (bad < 5) $display("FAIL long_trap c%0d got=%h exp=%h", i, got, exp_s);
        bad++;
      end
    end
    trap_req = 0;
    sb.push_back(exp_of(2, 0));
    tick();
    got = sample(); exp_s = sb.pop_front(); n_tests++;
    if (got !== exp_s) begin n_fail++; $display("FAIL long_trap_handoff got=%h exp=%h", got, exp_s); end
  endtask

  task automatic test_simultaneous();
    trap_req = 1; ins_req = 0;
    sb.push_back(exp_of(1, 0));
    tick();
    got = sample(); exp_s = sb.pop_front(); n_tests++;
    if (got !== exp_s) begin n_fail++; $display("FAIL simul_handoff got=%h exp=%h", got, exp_s); end
    trap_req = 0; trap_write_enable = 0;
    sb.push_back(exp_of(0, 0));
    tick();
    got = sample(); exp_s = sb.pop_front(); n_tests++;
    if (got !== exp_s) begin n_fail++; $display("FAIL simul_idle got=%h exp=%h", got, exp_s); end
  endtask

  task automatic test_reset_mid();
    ins_req = 1; ins_write_enable = 1; ins_address = 12'h300; ins_write_data = 32'h0000_1888;
    sb.push_back(exp_of(2, 0));
    tick();
    got = sample(); exp_s = sb.pop_front(); n_tests++;
    if (got !== exp_s) begin n_fail++; $display("FAIL pre_reset_ins got=%h exp=%h", got, exp_s); end
    #2 rst = 1'b1;
    #1;
    sb.push_back(exp_of(0, 0));
    got = sample(); exp_s = sb.pop_front(); n_tests++;
    if (got !== exp_s) begin n_fail++; $display("FAIL async_reset got=%h exp=%h", got, exp_s); end
    trap_req = 1; trap_write_enable = 1; trap_address = 12'h341;
    sb.push_back(exp_of(0, 0));
    tick();
    got = sample(); exp_s = sb.pop_front(); n_tests++;
    if (got !== exp_s) begin n_fail++; $display("FAIL held_reset got=%h exp=%h", got, exp_s); end
    rst = 1'b0;
    sb.push_back(exp_of(1, 0));
    tick();
    got = sample(); exp_s = sb.pop_front(); n_tests++;
    if (got !== exp_s) begin n_fail++; $display("FAIL post_reset_tie got=%h exp=%h", got, exp_s); end
  endtask

  initial begin
    test_reset();
    test_trap_grant();
    test_tie_and_handoff();
    test_write_isolation();
    test_revocation();
    test_long_trap();
    test_simultaneous();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
